// File: rtl/mem_pkg.sv
// Shared encodings for the memory-side responder: bus selector codes,
// load/serve state and the read-data source tag.
package mem_pkg;

   localparam int unsigned WIDTH_DEF   = 16;
   localparam logic [15:0] IO_ADDR_DEF = 16'hFFF0;

   typedef enum logic [1:0] {
      SEL_INSTR = 2'd0,
      SEL_DADO  = 2'd1,
      SEL_IMED  = 2'd2,
      SEL_RSVD  = 2'd3
   } sel_e;

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_SERVE = 1'b1
   } state_e;

   // Which source drives DadoEntrada in the cycle after a request.
   typedef enum logic [1:0] {
      RD_ZERO = 2'd0,
      RD_IMEM = 2'd1,
      RD_DMEM = 2'd2,
      RD_IO   = 2'd3
   } rd_src_e;

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM, read-before-write, one-cycle registered read.
module sync_ram #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 256,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Read samples the pre-write contents, giving read-before-write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the 16-bit multicycle bus: instruction/immediate/data
// reads, data and LED stores, and a streaming loader that gates Run.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned     WIDTH      = WIDTH_DEF,
   parameter int unsigned     IMEM_DEPTH = 256,
   parameter int unsigned     DMEM_DEPTH = 256,
   parameter logic [WIDTH-1:0] IO_ADDR   = WIDTH'(IO_ADDR_DEF),
   localparam int unsigned    IAW        = $clog2(IMEM_DEPTH),
   localparam int unsigned    DAW        = $clog2(DMEM_DEPTH),
   localparam int unsigned    CW         = IAW + 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Addr,
   input  logic [WIDTH-1:0] DadoEscrita,
   input  logic             W_D,
   input  logic [1:0]       SelecionaMemoria,
   output logic [WIDTH-1:0] DadoEntrada,
   output logic             Run,
   input  logic             Carrega,
   input  logic             CarregaValido,
   input  logic [WIDTH-1:0] CarregaDado,
   output logic             CarregaPronto,
   output logic [CW-1:0]    ContagemCarga,
   output logic [WIDTH-1:0] Leds
);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] leds_q, leds_d;
   logic [WIDTH-1:0] io_rd_q, io_rd_d;
   rd_src_e          src_q, src_d;

   logic             serve;
   logic             pronto;
   logic             load_acc;
   logic             is_io;
   logic             dat_wr;
   logic [IAW-1:0]   imem_addr;
   logic             imem_we;
   logic             dmem_we;
   logic [WIDTH-1:0] imem_rdata;
   logic [WIDTH-1:0] dmem_rdata;

   assign serve    = (state_q == ST_SERVE);
   assign pronto   = !serve && (cnt_q < CW'(IMEM_DEPTH));
   assign load_acc = pronto && CarregaValido;
   assign is_io    = (Addr == IO_ADDR);
   assign dat_wr   = serve && W_D && (sel_e'(SelecionaMemoria) == SEL_DADO);

   // Loader owns the imem port in LOAD; the processor reads it in SERVE.
   always_comb begin
      imem_addr = cnt_q[IAW-1:0];
      if (serve) begin
         if (sel_e'(SelecionaMemoria) == SEL_IMED) begin
            imem_addr = Addr[IAW-1:0] + IAW'(1);
         end else begin
            imem_addr = Addr[IAW-1:0];
         end
      end
   end

   // Reset suppresses any write that coincides with it.
   assign imem_we = load_acc && !Reset;
   assign dmem_we = dat_wr && !is_io && !Reset;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      leds_d  = leds_q;
      io_rd_d = leds_q;
      src_d   = RD_ZERO;
      case (state_q)
         ST_LOAD: begin
            if (load_acc) begin
               cnt_d = cnt_q + CW'(1);
            end
            if (!Carrega && (cnt_q != '0)) begin
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            case (sel_e'(SelecionaMemoria))
               SEL_INSTR, SEL_IMED: src_d = RD_IMEM;
               SEL_DADO:            src_d = is_io ? RD_IO : RD_DMEM;
               default:             src_d = RD_ZERO;
            endcase
            if (dat_wr && is_io) begin
               leds_d = DadoEscrita;
            end
            if (Carrega) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
         leds_q  <= '0;
         io_rd_q <= '0;
         src_q   <= RD_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         leds_q  <= leds_d;
         io_rd_q <= io_rd_d;
         src_q   <= src_d;
      end
   end

   sync_ram #(.WIDTH(WIDTH), .DEPTH(IMEM_DEPTH)) u_imem (
      .clk   (Clock),
      .we    (imem_we),
      .addr  (imem_addr),
      .wdata (CarregaDado),
      .rdata (imem_rdata)
   );

   sync_ram #(.WIDTH(WIDTH), .DEPTH(DMEM_DEPTH)) u_dmem (
      .clk   (Clock),
      .we    (dmem_we),
      .addr  (Addr[DAW-1:0]),
      .wdata (DadoEscrita),
      .rdata (dmem_rdata)
   );

   // Source tag and LED snapshot were captured at the request edge.
   always_comb begin
      case (src_q)
         RD_IMEM: DadoEntrada = imem_rdata;
         RD_DMEM: DadoEntrada = dmem_rdata;
         RD_IO:   DadoEntrada = io_rd_q;
         default: DadoEntrada = '0;
      endcase
   end

   assign Run           = serve;
   assign CarregaPronto = pronto;
   assign ContagemCarga = cnt_q;
   assign Leds          = leds_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against an array-based
// reference model of the load/serve behaviour.
module tb_mem_responder;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] Addr;
   logic [15:0] DadoEscrita;
   logic        W_D;
   logic [1:0]  sel_in;
   logic [15:0] DadoEntrada;
   logic        Run;
   logic        Carrega;
   logic        CarregaValido;
   logic [15:0] CarregaDado;
   logic        CarregaPronto;
   logic [8:0]  ContagemCarga;
   logic [15:0] Leds;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit          m_serve;
   int          m_cnt;
   logic [15:0] m_leds;
   logic [15:0] m_rd;
   bit          m_rd_known;
   logic [15:0] m_imem [256];
   logic [15:0] m_dmem [256];
   bit          m_ik   [256];
   bit          m_dk   [256];

   mem_responder dut (
      .Clock            (Clock),
      .Reset            (Reset),
      .Addr             (Addr),
      .DadoEscrita      (DadoEscrita),
      .W_D              (W_D),
      .SelecionaMemoria (sel_in),
      .DadoEntrada      (DadoEntrada),
      .Run              (Run),
      .Carrega          (Carrega),
      .CarregaValido    (CarregaValido),
      .CarregaDado      (CarregaDado),
      .CarregaPronto    (CarregaPronto),
      .ContagemCarga    (ContagemCarga),
      .Leds             (Leds)
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one clock edge of the specified behaviour to the model.
   task automatic model_edge();
      int idx;
      int old_cnt;
      idx = int'(Addr) % 256;
      if (Reset) begin
         m_serve = 0; m_cnt = 0; m_leds = '0; m_rd = '0; m_rd_known = 1;
      end else if (m_serve) begin
         case (sel_in)
            2'd0: begin m_rd = m_imem[idx]; m_rd_known = m_ik[idx]; end
            2'd2: begin m_rd = m_imem[(idx + 1) % 256]; m_rd_known = m_ik[(idx + 1) % 256]; end
            2'd1: begin
               if (Addr == 16'hFFF0) begin m_rd = m_leds; m_rd_known = 1; end
               else begin m_rd = m_dmem[idx]; m_rd_known = m_dk[idx]; end
            end
            default: begin m_rd = '0; m_rd_known = 1; end
         endcase
         if (W_D && sel_in == 2'd1) begin
            if (Addr == 16'hFFF0) m_leds = DadoEscrita;
            else begin m_dmem[idx] = DadoEscrita; m_dk[idx] = 1; end
         end
         if (Carrega) begin m_serve = 0; m_cnt = 0; end
      end else begin
         m_rd = '0; m_rd_known = 1;
         old_cnt = m_cnt;
         if (CarregaValido && m_cnt < 256) begin
            m_imem[m_cnt] = CarregaDado; m_ik[m_cnt] = 1; m_cnt++;
         end
         if (!Carrega && old_cnt != 0) m_serve = 1;
      end
   endtask

   task automatic step();
      @(posedge Clock);
      model_edge();
      #1;
      if (m_rd_known) check_eq("rd_data", 32'(DadoEntrada), 32'(m_rd));
      check_eq("run", 32'(Run), 32'(m_serve));
      check_eq("pronto", 32'(CarregaPronto), 32'(!m_serve && m_cnt < 256));
      check_eq("count", 32'(ContagemCarga), 32'(m_cnt));
      check_eq("leds", 32'(Leds), 32'(m_leds));
   endtask

   task automatic idle();
      Reset = 0; Addr = '0; DadoEscrita = '0; W_D = 0; sel_in = 2'd3;
      Carrega = 0; CarregaValido = 0; CarregaDado = '0;
   endtask

   task automatic load_word(input logic [15:0] w);
      Carrega = 1; CarregaValido = 1; CarregaDado = w; step();
      CarregaValido = 0;
   endtask

   task automatic rd(input logic [1:0] s, input logic [15:0] a);
      W_D = 0; sel_in = s; Addr = a; step();
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      W_D = 1; sel_in = 2'd1; Addr = a; DadoEscrita = d; step(); W_D = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin m_ik[i] = 0; m_dk[i] = 0; end
      m_serve = 0; m_cnt = 0; m_leds = '0; m_rd = '0; m_rd_known = 0;
      idle();
      #1;

      // Reset state
      Reset = 1; Carrega = 1; step(); step();
      check_eq("rst_rd", 32'(DadoEntrada), 32'h0);
      check_eq("rst_pronto", 32'(CarregaPronto), 32'h1);
      Reset = 0;

      // Load a 3-word program
      load_word(16'h0011); load_word(16'h0042); load_word(16'h0002);
      Carrega = 0; step();
      check_eq("ld_cnt", 32'(ContagemCarga), 32'd3);
      check_eq("ld_run", 32'(Run), 32'd1);
      rd(2'd0, 16'h0000);
      check_eq("ld_instr", 32'(DadoEntrada), 32'h0011);
      rd(2'd2, 16'h0000);
      check_eq("ld_imed", 32'(DadoEntrada), 32'h0042);

      // Data store / load with aliasing
      wr(16'h0005, 16'hBEEF);
      rd(2'd1, 16'h0005);
      check_eq("dmem_rd", 32'(DadoEntrada), 32'hBEEF);
      rd(2'd1, 16'h0105);
      check_eq("dmem_alias", 32'(DadoEntrada), 32'hBEEF);

      // LED register does not touch dmem[F0]
      wr(16'h00F0, 16'h5A5A);
      wr(16'hFFF0, 16'h00A5);
      check_eq("leds_wr", 32'(Leds), 32'h00A5);
      rd(2'd1, 16'hFFF0);
      check_eq("leds_rd", 32'(DadoEntrada), 32'h00A5);
      rd(2'd1, 16'h00F0);
      check_eq("dmem_f0", 32'(DadoEntrada), 32'h5A5A);

      // Read-before-write on dmem and Leds
      wr(16'h0005, 16'h1111);
      check_eq("rbw_dmem", 32'(DadoEntrada), 32'hBEEF);
      wr(16'hFFF0, 16'h0077);
      check_eq("rbw_leds", 32'(DadoEntrada), 32'h00A5);

      // Reload imem[0]=1234, immediate wrap, ignored instruction-space store
      Carrega = 1; step();
      load_word(16'h1234);
      Carrega = 0; step();
      rd(2'd2, 16'h00FF);
      check_eq("imed_wrap", 32'(DadoEntrada), 32'h1234);
      W_D = 1; sel_in = 2'd0; Addr = 16'h0000; DadoEscrita = 16'hDEAD; step(); W_D = 0;
      rd(2'd0, 16'h0000);
      check_eq("ign_store", 32'(DadoEntrada), 32'h1234);
      rd(2'd1, 16'h0000);
      rd(2'd3, 16'h0005);
      check_eq("sel3_zero", 32'(DadoEntrada), 32'h0);

      // Full load: 260 words offered, 256 accepted
      Carrega = 1; step();
      for (int i = 0; i < 260; i++) begin
         Carrega = 1; CarregaValido = 1; CarregaDado = 16'($urandom); step();
      end
      check_eq("full_cnt", 32'(ContagemCarga), 32'd256);
      check_eq("full_pronto", 32'(CarregaPronto), 32'd0);
      CarregaValido = 0; Carrega = 0; step();

      // Randomized traffic with occasional reloads
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       Addr = 16'hFFF0;
            1:       Addr = 16'($urandom_range(0, 15));
            2:       Addr = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 15))};
            default: Addr = 16'($urandom);
         endcase
         sel_in      = 2'($urandom_range(0, 3));
         W_D         = ($urandom_range(0, 2) == 0);
         DadoEscrita = 16'($urandom);
         CarregaValido = 1'($urandom_range(0, 1));
         CarregaDado   = 16'($urandom);
         if (m_serve) Carrega = ($urandom_range(0, 149) == 0);
         else         Carrega = ($urandom_range(0, 7) != 0);
         step();
      end
      idle();

      // Ensure SERVE, then reset coincident with a store
      if (!m_serve) begin
         load_word(16'h0001);
         Carrega = 0; step();
      end
      wr(16'h0007, 16'h7777);
      Reset = 1; W_D = 1; sel_in = 2'd1; Addr = 16'h0007; DadoEscrita = 16'h1111; step();
      check_eq("rst_store_run", 32'(Run), 32'd0);
      idle();
      load_word(16'h0001);
      Carrega = 0; step();
      rd(2'd1, 16'h0007);
      check_eq("rst_store_kept", 32'(DadoEntrada), 32'h7777);

      // Reset after 2 of 5 load words, then empty load
      wr(16'hFFF0, 16'h00C3);
      Carrega = 1; step();
      load_word(16'hAAAA); load_word(16'hBBBB);
      Reset = 1; Carrega = 1; CarregaValido = 1; CarregaDado = 16'hCCCC; step();
      check_eq("rl_cnt", 32'(ContagemCarga), 32'd0);
      check_eq("rl_leds", 32'(Leds), 32'd0);
      check_eq("rl_run", 32'(Run), 32'd0);
      idle();
      for (int i = 0; i < 4; i++) step();
      check_eq("empty_run", 32'(Run), 32'd0);
      check_eq("empty_pronto", 32'(CarregaPronto), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
